// File: rtl/rv32i_multicycle_core.sv
// Multicycle RV32I core (no FENCE/ECALL/EBREAK/CSR) with split imem/dmem request/resp ports.
// Define RVFI_EN to add the rvfi_* retirement-trace outputs.
module rv32i_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_resp
`ifdef RVFI_EN
    ,
    output logic        rvfi_valid,
    output logic [63:0] rvfi_order,
    output logic [31:0] rvfi_insn,
    output logic [4:0]  rvfi_rs1_addr,
    output logic [31:0] rvfi_rs1_rdata,
    output logic [4:0]  rvfi_rs2_addr,
    output logic [31:0] rvfi_rs2_rdata,
    output logic [4:0]  rvfi_rd_addr,
    output logic [31:0] rvfi_rd_wdata,
    output logic [31:0] rvfi_pc_rdata,
    output logic [31:0] rvfi_pc_wdata,
    output logic [31:0] rvfi_mem_addr,
    output logic [3:0]  rvfi_mem_rmask,
    output logic [3:0]  rvfi_mem_wmask,
    output logic [31:0] rvfi_mem_rdata,
    output logic [31:0] rvfi_mem_wdata,
    output logic        rvfi_halt
`endif
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef enum logic [2:0] {StFetchReq, StFetchWait, StExec, StMemReq, StMemWait, StWb} state_e;

    state_e      state;
    logic [31:0] pc, ir, next_pc_q, wb_val_q;
    logic        wb_en_q;
    logic [1:0]  ld_off_q;
    logic [2:0]  ld_f3_q;
    logic [31:0] regs [32];

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v, op_b, sra_res, alu_res, ea, lane, load_val;
    logic [31:0] ex_val, ex_npc;
    logic [3:0]  lane_mask;
    logic        alu_ok, taken, misaligned, ex_wen, ex_mem, ex_store;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    // regs[0] is reset and never written, so it always reads 0
    assign rs1_v  = regs[rs1];
    assign rs2_v  = regs[rs2];

    always_comb begin
        op_b    = (opcode == OpReg) ? rs2_v : imm_i;
        sra_res = $signed(rs1_v) >>> op_b[4:0];
        case (f3)
            3'd0:    alu_res = (opcode == OpReg && f7[5]) ? rs1_v - op_b : rs1_v + op_b;
            3'd1:    alu_res = rs1_v << op_b[4:0];
            3'd2:    alu_res = {31'b0, $signed(rs1_v) < $signed(op_b)};
            3'd3:    alu_res = {31'b0, rs1_v < op_b};
            3'd4:    alu_res = rs1_v ^ op_b;
            3'd5:    alu_res = f7[5] ? sra_res : rs1_v >> op_b[4:0];
            3'd6:    alu_res = rs1_v | op_b;
            default: alu_res = rs1_v & op_b;
        endcase
        if (opcode == OpReg)    alu_ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (f3 == 3'd1)    alu_ok = (f7 == 7'h00);
        else if (f3 == 3'd5)    alu_ok = (f7 == 7'h00) || (f7 == 7'h20);
        else                    alu_ok = 1'b1;
        case (f3)
            3'd0:    taken = (rs1_v == rs2_v);
            3'd1:    taken = (rs1_v != rs2_v);
            3'd4:    taken = ($signed(rs1_v) < $signed(rs2_v));
            3'd5:    taken = ($signed(rs1_v) >= $signed(rs2_v));
            3'd6:    taken = (rs1_v < rs2_v);
            3'd7:    taken = (rs1_v >= rs2_v);
            default: taken = 1'b0;
        endcase
        ea = rs1_v + ((opcode == OpStore) ? imm_s : imm_i);
        case (f3[1:0])
            2'd0:    lane_mask = 4'b0001 << ea[1:0];
            2'd1:    lane_mask = 4'b0011 << ea[1:0];
            default: lane_mask = 4'b1111;
        endcase
        misaligned = (f3[1:0] == 2'd1 && ea[0]) || (f3[1:0] == 2'd2 && ea[1:0] != 2'b00);
    end

    always_comb begin
        ex_wen   = 1'b0;
        ex_val   = alu_res;
        ex_npc   = pc + 32'd4;
        ex_mem   = 1'b0;
        ex_store = 1'b0;
        case (opcode)
            OpLui:   begin ex_wen = 1'b1; ex_val = imm_u; end
            OpAuipc: begin ex_wen = 1'b1; ex_val = pc + imm_u; end
            OpJal:   begin ex_wen = 1'b1; ex_val = pc + 32'd4; ex_npc = pc + imm_j; end
            OpJalr: begin
                if (f3 == 3'd0) begin
                    ex_wen = 1'b1;
                    ex_val = pc + 32'd4;
                    ex_npc = (rs1_v + imm_i) & ~32'd1;
                end
            end
            OpBranch: if (taken) ex_npc = pc + imm_b;
            // Misaligned or unknown-width accesses retire as NOPs with no request
            OpLoad: begin
                if (f3 != 3'd3 && f3[2:1] != 2'b11 && !misaligned) begin
                    ex_mem = 1'b1;
                    ex_wen = 1'b1;
                end
            end
            OpStore: begin
                if (!f3[2] && f3 != 3'd3 && !misaligned) begin
                    ex_mem   = 1'b1;
                    ex_store = 1'b1;
                end
            end
            OpImm, OpReg: ex_wen = alu_ok;
            default: ;
        endcase
    end

    always_comb begin
        lane = dmem_rdata >> {ld_off_q, 3'b000};
        case (ld_f3_q)
            3'd0:    load_val = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_val = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_val = {24'b0, lane[7:0]};
            3'd5:    load_val = {16'b0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StFetchReq;
            pc         <= RESET_PC;
            ir         <= '0;
            next_pc_q  <= '0;
            wb_val_q   <= '0;
            wb_en_q    <= 1'b0;
            ld_off_q   <= '0;
            ld_f3_q    <= '0;
            imem_addr  <= '0;
            imem_rmask <= '0;
            dmem_addr  <= '0;
            dmem_rmask <= '0;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                StFetchReq: begin
                    // The first fetch after reset needs one cycle to raise the mask
                    if (imem_rmask == 4'hF) begin
                        imem_rmask <= '0;
                        state      <= StFetchWait;
                    end else begin
                        imem_rmask <= 4'hF;
                        imem_addr  <= {pc[31:2], 2'b00};
                    end
                end
                StFetchWait: begin
                    if (imem_resp) begin
                        ir    <= imem_rdata;
                        state <= StExec;
                    end
                end
                StExec: begin
                    next_pc_q <= ex_npc;
                    wb_val_q  <= ex_val;
                    wb_en_q   <= ex_wen;
                    ld_off_q  <= ea[1:0];
                    ld_f3_q   <= f3;
                    if (ex_mem) begin
                        dmem_addr <= {ea[31:2], 2'b00};
                        if (ex_store) begin
                            dmem_wmask <= lane_mask;
                            dmem_wdata <= rs2_v << {ea[1:0], 3'b000};
                        end else begin
                            dmem_rmask <= lane_mask;
                        end
                        state <= StMemReq;
                    end else begin
                        state <= StWb;
                    end
                end
                StMemReq: begin
                    dmem_rmask <= '0;
                    dmem_wmask <= '0;
                    state      <= StMemWait;
                end
                StMemWait: begin
                    if (dmem_resp) begin
                        if (wb_en_q) wb_val_q <= load_val;
                        state <= StWb;
                    end
                end
                StWb: begin
                    if (wb_en_q && rd != 5'd0) regs[rd] <= wb_val_q;
                    pc         <= next_pc_q;
                    imem_addr  <= {next_pc_q[31:2], 2'b00};
                    imem_rmask <= 4'hF;
                    state      <= StFetchReq;
                end
                default: state <= StFetchReq;
            endcase
        end
    end

`ifdef RVFI_EN
    logic [63:0] order_q;
    logic [31:0] rs1_q, rs2_q, maddr_q, mrdata_q, mwdata_q;
    logic [3:0]  mrmask_q, mwmask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_q  <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            maddr_q  <= '0;
            mrdata_q <= '0;
            mwdata_q <= '0;
            mrmask_q <= '0;
            mwmask_q <= '0;
        end else begin
            if (state == StExec) begin
                rs1_q    <= rs1_v;
                rs2_q    <= rs2_v;
                maddr_q  <= ex_mem ? {ea[31:2], 2'b00} : '0;
                mrmask_q <= (ex_mem && !ex_store) ? lane_mask : '0;
                mwmask_q <= (ex_mem && ex_store) ? lane_mask : '0;
                mwdata_q <= (ex_mem && ex_store) ? rs2_v << {ea[1:0], 3'b000} : '0;
                mrdata_q <= '0;
            end
            if (state == StMemWait && dmem_resp) mrdata_q <= dmem_rdata;
            if (state == StWb) order_q <= order_q + 64'd1;
        end
    end

    assign rvfi_valid     = (state == StWb);
    assign rvfi_order     = order_q;
    assign rvfi_insn      = ir;
    assign rvfi_rs1_addr  = rs1;
    assign rvfi_rs1_rdata = rs1_q;
    assign rvfi_rs2_addr  = rs2;
    assign rvfi_rs2_rdata = rs2_q;
    assign rvfi_rd_addr   = wb_en_q ? rd : 5'd0;
    assign rvfi_rd_wdata  = (wb_en_q && rd != 5'd0) ? wb_val_q : '0;
    assign rvfi_pc_rdata  = pc;
    assign rvfi_pc_wdata  = next_pc_q;
    assign rvfi_mem_addr  = maddr_q;
    assign rvfi_mem_rmask = mrmask_q;
    assign rvfi_mem_wmask = mwmask_q;
    assign rvfi_mem_rdata = mrdata_q;
    assign rvfi_mem_wdata = mwdata_q;
    assign rvfi_halt      = (next_pc_q == pc);
`endif

endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Scoreboard bench for rv32i_multicycle_core: expected memory requests are queued by the
// stimulus and a monitor compares every fetch/load/store request the core issues.
module tb_rv32i_multicycle_core;

    localparam logic [31:0] B    = 32'h1eceb000;
    localparam logic [6:0]  OIMM = 7'b0010011;
    localparam logic [6:0]  OLD  = 7'b0000011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_rdata, dmem_wdata;
    logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
    logic        imem_resp, dmem_resp;

    always #5 clk = ~clk;

    rv32i_multicycle_core #(.RESET_PC(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_rdata (dmem_rdata),
        .dmem_wdata (dmem_wdata),
        .dmem_resp  (dmem_resp)
    );

    typedef struct {
        int          kind;  // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          ev_idx = 0;
    bit          mon_en = 1'b0;
    bit          imem_auto = 1'b0;
    bit          late_req = 1'b0;
    int          imem_lat = 3;
    int          dmem_lat = 2;
    logic [31:0] imem_mem [logic [31:0]];
    logic [31:0] dmem_mem [logic [31:0]];

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic push(input int kind, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.addr = addr; e.mask = mask; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pf(input logic [31:0] addr);
        push(0, addr, 4'hF, 32'h0);
    endtask

    task automatic observe(input int kind, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL event%0d: got unexpected kind=%0d addr=%h mask=%h data=%h, required none",
                     ev_idx, kind, addr, mask, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.addr === addr && e.mask === mask && e.data === data)
                n_pass++;
            else
                $display("FAIL event%0d: got kind=%0d addr=%h mask=%h data=%h, required kind=%0d addr=%h mask=%h data=%h",
                         ev_idx, kind, addr, mask, data, e.kind, e.addr, e.mask, e.data);
        end
        ev_idx++;
    endtask

    // Instruction memory responder
    initial begin : imem_model
        logic [31:0] ia;
        int          icnt;
        bit          ibusy;
        bit          late_done;
        ibusy = 1'b0; icnt = 0; ia = '0; late_done = 1'b0;
        imem_resp = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_resp = 1'b0;
            if (late_req && !late_done) begin
                late_done  = 1'b1;
                imem_rdata = enc_s(12'h000, 5'd0, 5'd0, 3'd2);
                imem_resp  = 1'b1;
            end
            if (rst) begin
                ibusy = 1'b0;
            end else if (ibusy) begin
                icnt = icnt - 1;
                if (icnt == 0) begin
                    imem_rdata = imem_mem.exists(ia) ? imem_mem[ia] : 32'h00000013;
                    imem_resp  = 1'b1;
                    ibusy      = 1'b0;
                end
            end else if (imem_auto && imem_rmask != 4'h0) begin
                ia    = {imem_addr[31:2], 2'b00};
                icnt  = imem_lat;
                ibusy = 1'b1;
            end
        end
    end

    // Data memory responder
    initial begin : dmem_model
        logic [31:0] da, dwd, cur;
        logic [3:0]  dwm;
        int          dcnt;
        bit          dbusy;
        dbusy = 1'b0; dcnt = 0; da = '0; dwd = '0; dwm = '0; cur = '0;
        dmem_resp = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_resp = 1'b0;
            if (rst) begin
                dbusy = 1'b0;
            end else if (dbusy) begin
                dcnt = dcnt - 1;
                if (dcnt == 0) begin
                    cur = dmem_mem.exists(da) ? dmem_mem[da] : 32'h0;
                    for (int b = 0; b < 4; b++) if (dwm[b]) cur[8*b +: 8] = dwd[8*b +: 8];
                    dmem_mem[da] = cur;
                    dmem_rdata   = cur;
                    dmem_resp    = 1'b1;
                    dbusy        = 1'b0;
                end
            end else if (dmem_rmask != 4'h0 || dmem_wmask != 4'h0) begin
                da    = dmem_addr;
                dwm   = dmem_wmask;
                dwd   = dmem_wdata;
                dcnt  = dmem_lat;
                dbusy = 1'b1;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en && imem_rmask != 4'h0)
                observe(0, {imem_addr[31:2], 2'b00}, imem_rmask, 32'h0);
            if (mon_en && dmem_wmask != 4'h0)
                observe(2, dmem_addr, dmem_wmask, dmem_wdata);
            else if (mon_en && dmem_rmask != 4'h0)
                observe(1, dmem_addr, dmem_rmask, 32'h0);
        end
    end

    initial begin : stimulus
        imem_mem[B + 32'h00] = enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, OIMM);    // addi x1,x0,-5
        imem_mem[B + 32'h04] = enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd2);      // sltu x2,x0,x1
        imem_mem[B + 32'h08] = enc_i(12'h401, 5'd1, 3'd5, 5'd3, OIMM);    // srai x3,x1,1
        imem_mem[B + 32'h0C] = enc_i(12'h100, 5'd0, 3'd0, 5'd4, OIMM);    // addi x4,x0,0x100
        imem_mem[B + 32'h10] = enc_s(12'd0, 5'd1, 5'd4, 3'd2);            // sw x1,0(x4)
        imem_mem[B + 32'h14] = enc_s(12'd4, 5'd2, 5'd4, 3'd2);            // sw x2,4(x4)
        imem_mem[B + 32'h18] = enc_s(12'd8, 5'd3, 5'd4, 3'd2);            // sw x3,8(x4)
        imem_mem[B + 32'h1C] = enc_i(12'd3, 5'd4, 3'd0, 5'd5, OLD);       // lb x5,3(x4)
        imem_mem[B + 32'h20] = enc_s(12'd12, 5'd5, 5'd4, 3'd2);           // sw x5,12(x4)
        imem_mem[B + 32'h24] = enc_s(12'd1, 5'd0, 5'd4, 3'd0);            // sb x0,1(x4)
        imem_mem[B + 32'h28] = enc_s(12'd2, 5'd1, 5'd4, 3'd1);            // sh x1,2(x4)
        imem_mem[B + 32'h2C] = enc_i(12'd1, 5'd4, 3'd2, 5'd7, OLD);       // lw x7,1(x4) misaligned
        imem_mem[B + 32'h30] = enc_s(12'd16, 5'd7, 5'd4, 3'd2);           // sw x7,16(x4)
        imem_mem[B + 32'h34] = enc_b(13'd8, 5'd0, 5'd0, 3'd0);            // beq x0,x0,+8
        imem_mem[B + 32'h38] = enc_s(12'd20, 5'd1, 5'd4, 3'd2);           // skipped
        imem_mem[B + 32'h3C] = enc_b(13'd8, 5'd0, 5'd0, 3'd1);            // bne x0,x0,+8
        imem_mem[B + 32'h40] = enc_i(12'h200, 5'd0, 3'd0, 5'd1, OIMM);    // addi x1,x0,0x200
        imem_mem[B + 32'h44] = enc_i(12'd3, 5'd1, 3'd0, 5'd6, 7'b1100111); // jalr x6,x1,3
        imem_mem[32'h200]    = enc_s(12'd20, 5'd6, 5'd4, 3'd2);           // sw x6,20(x4)
        imem_mem[32'h204]    = enc_i(12'd7, 5'd0, 3'd0, 5'd0, OIMM);      // addi x0,x0,7
        imem_mem[32'h208]    = enc_s(12'd24, 5'd0, 5'd4, 3'd2);           // sw x0,24(x4)
        imem_mem[32'h20C]    = enc_j(21'd0, 5'd0);                        // jal x0,0

        repeat (3) @(negedge clk);
        chk("reset_masks", {20'h0, imem_rmask, dmem_rmask, dmem_wmask}, 32'h0);
        chk("reset_addr_wdata", imem_addr | dmem_addr | dmem_wdata, 32'h0);

        pf(B);
        mon_en = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 20 && imem_rmask == 4'h0; i++) @(negedge clk);
        chk("first_fetch_seen", {31'h0, imem_rmask != 4'h0}, 32'h1);

        // Abandon the first fetch while it waits for a response
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_masks", {20'h0, imem_rmask, dmem_rmask, dmem_wmask}, 32'h0);
        chk("midreset_addr", imem_addr | dmem_addr | dmem_wdata, 32'h0);

        pf(B);      pf(B + 32'h04); pf(B + 32'h08); pf(B + 32'h0C); pf(B + 32'h10);
        push(2, 32'h100, 4'hF, 32'hFFFFFFFB);
        pf(B + 32'h14); push(2, 32'h104, 4'hF, 32'h00000001);
        pf(B + 32'h18); push(2, 32'h108, 4'hF, 32'hFFFFFFFD);
        pf(B + 32'h1C); push(1, 32'h100, 4'b1000, 32'h0);
        pf(B + 32'h20); push(2, 32'h10C, 4'hF, 32'hFFFFFFFF);
        pf(B + 32'h24); push(2, 32'h100, 4'b0010, 32'h00000000);
        pf(B + 32'h28); push(2, 32'h100, 4'b1100, 32'hFFFB0000);
        pf(B + 32'h2C);
        pf(B + 32'h30); push(2, 32'h110, 4'hF, 32'h00000000);
        pf(B + 32'h34); pf(B + 32'h3C); pf(B + 32'h40); pf(B + 32'h44);
        pf(32'h200);    push(2, 32'h114, 4'hF, B + 32'h48);
        pf(32'h204);
        pf(32'h208);    push(2, 32'h118, 4'hF, 32'h00000000);
        pf(32'h20C);    pf(32'h20C); pf(32'h20C);

        // A stale response lands in the first cycle after release and must be ignored
        @(posedge clk);
        late_req  = 1'b1;
        imem_auto = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
        mon_en = 1'b0;
        chk("events_outstanding", exp_q.size(), 32'h0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
